// File: rtl/quicksort_main.sv
`default_nettype none
// ============================================================================
//  Module   : quicksort_main
//  Purpose  : Sorts an 11-element array of signed 32-bit integers held in an
//             internal 44-byte RAM, ascending and in place, using an
//             iterative quicksort with Lomuto partitioning and an explicit
//             range stack. A two-channel byte-wide slave bus gives external
//             read/write access to the array while the sorter is idle.
//  Ports    : clock, reset (sync, active-high), start_port / done_port
//             handshake, S_* slave request inputs, Sout_* slave responses,
//             M_* / Mout_* master bus (inputs ignored, outputs tied to 0).
//  Revision : 1.0  initial release
// ============================================================================
module quicksort_main #(
    parameter int MEM_var_28860_28869 = 32,
    parameter int MEM_var_29126_28866 = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic [1:0]  S_oe_ram,
    input  logic [1:0]  S_we_ram,
    input  logic [13:0] S_addr_ram,
    input  logic [15:0] S_Wdata_ram,
    input  logic [7:0]  S_data_ram_size,
    input  logic [15:0] M_Rdata_ram,
    input  logic [1:0]  M_DataRdy,
    output logic        done_port,
    output logic [15:0] Sout_Rdata_ram,
    output logic [1:0]  Sout_DataRdy,
    output logic [1:0]  Mout_oe_ram,
    output logic [1:0]  Mout_we_ram,
    output logic [13:0] Mout_addr_ram,
    output logic [15:0] Mout_Wdata_ram,
    output logic [7:0]  Mout_data_ram_size
);

    localparam int N_ELEM      = 11;
    localparam int N_BYTES     = 4 * N_ELEM;
    localparam int STACK_DEPTH = 11;

    // Array window and its result-view alias (both map onto the same bytes).
    localparam logic [7:0] BASE_A = 8'(MEM_var_28860_28869);
    localparam logic [7:0] LIM_A  = 8'(MEM_var_28860_28869 + N_BYTES);
    localparam logic [7:0] BASE_B = 8'(MEM_var_29126_28866);
    localparam logic [7:0] LIM_B  = 8'(MEM_var_29126_28866 + N_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_PART = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [7:0]         mem [N_BYTES];
    logic [31:0]        words [N_ELEM];

    logic signed [4:0]  stk_lo [STACK_DEPTH];
    logic signed [4:0]  stk_hi [STACK_DEPTH];
    logic [3:0]         sp;
    logic [3:0]         top_idx;
    logic signed [4:0]  top_lo, top_hi;

    logic [3:0]         part_lo, part_hi, part_i, part_j;
    logic               less;
    logic               swap_en;
    logic [3:0]         swap_y;
    logic [31:0]        word_x, word_y;

    logic               idle;
    logic [1:0]         rd_req, wr_req;
    logic [5:0]         s_idx  [2];
    logic [7:0]         s_mask [2];

    // Master bus is never used; its inputs are intentionally ignored.
    logic unused_master;
    assign unused_master = ^{M_Rdata_ram, M_DataRdy};

    assign Mout_oe_ram        = 2'b00;
    assign Mout_we_ram        = 2'b00;
    assign Mout_addr_ram      = 14'd0;
    assign Mout_Wdata_ram     = 16'd0;
    assign Mout_data_ram_size = 8'd0;

    // Preset image, element k little-endian at bytes 4k..4k+3.
    function automatic logic [31:0] preset_word(input int k);
        case (k)
            0:       preset_word = 32'd44;
            1:       preset_word = 32'd7;
            2:       preset_word = 32'hFFFF_FFFD;   // -3
            3:       preset_word = 32'd19;
            4:       preset_word = 32'd0;
            5:       preset_word = 32'd7;
            6:       preset_word = 32'd100;
            7:       preset_word = 32'hFFFF_FFCE;   // -50
            8:       preset_word = 32'd12;
            9:       preset_word = 32'd3;
            10:      preset_word = 32'd1;
            default: preset_word = 32'd0;
        endcase
    endfunction

    function automatic logic [7:0] preset_byte(input int b);
        logic [31:0] w;
        w = preset_word(b / 4);
        return w[8 * (b % 4) +: 8];
    endfunction

    // ------------------------------------------------------------------
    // Word view of the byte RAM
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_ELEM; k++) begin : g_word
        assign words[k] = {mem[4*k+3], mem[4*k+2], mem[4*k+1], mem[4*k]};
    end

    assign less   = $signed(words[part_j]) < $signed(words[part_hi]);
    assign word_x = words[part_i];
    assign word_y = words[swap_y];

    // Guard the empty-stack case so the top-of-stack read never goes out of range.
    assign top_idx = (sp == 4'd0) ? 4'd0 : sp - 4'd1;
    assign top_lo  = stk_lo[top_idx];
    assign top_hi  = stk_hi[top_idx];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        swap_en    = 1'b0;
        swap_y     = part_j;
        done_port  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_port) next_state = S_POP;
            end
            S_POP: begin
                if (sp == 4'd0)            next_state = S_DONE;
                else if (top_lo >= top_hi) next_state = S_POP;
                else                       next_state = S_PART;
            end
            S_PART: begin
                if (part_j < part_hi) begin
                    // Scan step: elements below the pivot move to the left region.
                    swap_en = less;
                    swap_y  = part_j;
                end else begin
                    // Scan finished: drop the pivot into its final slot.
                    swap_en    = 1'b1;
                    swap_y     = part_hi;
                    next_state = S_POP;
                end
            end
            S_DONE: begin
                done_port  = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Range stack and partition indices
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            sp      <= 4'd0;
            part_lo <= 4'd0;
            part_hi <= 4'd0;
            part_i  <= 4'd0;
            part_j  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_port) begin
                        stk_lo[0] <= 5'sd0;
                        stk_hi[0] <= 5'sd10;
                        sp        <= 4'd1;
                    end
                end
                S_POP: begin
                    if (sp != 4'd0) begin
                        sp      <= sp - 4'd1;
                        part_lo <= top_lo[3:0];
                        part_hi <= top_hi[3:0];
                        part_i  <= top_lo[3:0];
                        part_j  <= top_lo[3:0];
                    end
                end
                S_PART: begin
                    if (part_j < part_hi) begin
                        if (less) part_i <= part_i + 4'd1;
                        part_j <= part_j + 4'd1;
                    end else begin
                        // Both halves are pushed even if empty; POP discards
                        // them. Signed entries let p-1 reach -1 safely.
                        stk_lo[sp]        <= $signed({1'b0, part_lo});
                        stk_hi[sp]        <= $signed({1'b0, part_i}) - 5'sd1;
                        stk_lo[sp + 4'd1] <= $signed({1'b0, part_i}) + 5'sd1;
                        stk_hi[sp + 4'd1] <= $signed({1'b0, part_hi});
                        sp                <= sp + 4'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slave bus decode (only served while the sorter is idle)
    // ------------------------------------------------------------------
    assign idle = (state == S_IDLE);

    for (genvar c = 0; c < 2; c++) begin : g_chan
        logic [7:0] addr;
        logic       hit_a, hit_b;
        assign addr        = {1'b0, S_addr_ram[7*c +: 7]};
        assign hit_a       = (addr >= BASE_A) && (addr < LIM_A);
        assign hit_b       = (addr >= BASE_B) && (addr < LIM_B);
        assign s_idx[c]    = hit_a ? 6'(addr - BASE_A) : 6'(addr - BASE_B);
        assign s_mask[c]   = 8'((9'd1 << S_data_ram_size[4*c +: 4]) - 9'd1);
        // A request with both oe and we set is served as a read only.
        assign rd_req[c]   = idle && (hit_a || hit_b) && S_oe_ram[c];
        assign wr_req[c]   = idle && (hit_a || hit_b) && S_we_ram[c] && !S_oe_ram[c];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            Sout_Rdata_ram <= 16'd0;
            Sout_DataRdy   <= 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                Sout_DataRdy[c]          <= rd_req[c] | wr_req[c];
                Sout_Rdata_ram[8*c +: 8] <= rd_req[c] ? mem[s_idx[c]] : 8'h00;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM: preset on reset, sorter swaps while busy, slave writes while idle.
    // Channel 1 is applied last so it wins a same-byte collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int b = 0; b < N_BYTES; b++) mem[b] <= preset_byte(b);
        end else if (swap_en) begin
            for (int b = 0; b < 4; b++) begin
                mem[{part_i, 2'(b)}] <= word_y[8*b +: 8];
                mem[{swap_y, 2'(b)}] <= word_x[8*b +: 8];
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (wr_req[c]) begin
                    mem[s_idx[c]] <= (mem[s_idx[c]] & ~s_mask[c])
                                   | (S_Wdata_ram[8*c +: 8] & s_mask[c]);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quicksort_main.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quicksort_main
//  Purpose  : Self-checking bench for quicksort_main. Keeps a byte-level image
//             of the array, applies every slave write to it, and sorts it with
//             a plain insertion sort whenever the DUT is started.
//  Revision : 1.0  initial release
// ============================================================================
module tb_quicksort_main;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_port;
    logic [1:0]  S_oe_ram;
    logic [1:0]  S_we_ram;
    logic [13:0] S_addr_ram;
    logic [15:0] S_Wdata_ram;
    logic [7:0]  S_data_ram_size;
    logic [15:0] M_Rdata_ram;
    logic [1:0]  M_DataRdy;
    logic        done_port;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;
    logic [1:0]  Mout_oe_ram;
    logic [1:0]  Mout_we_ram;
    logic [13:0] Mout_addr_ram;
    logic [15:0] Mout_Wdata_ram;
    logic [7:0]  Mout_data_ram_size;

    quicksort_main #(
        .MEM_var_28860_28869(32),
        .MEM_var_29126_28866(32)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .start_port         (start_port),
        .S_oe_ram           (S_oe_ram),
        .S_we_ram           (S_we_ram),
        .S_addr_ram         (S_addr_ram),
        .S_Wdata_ram        (S_Wdata_ram),
        .S_data_ram_size    (S_data_ram_size),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy),
        .done_port          (done_port),
        .Sout_Rdata_ram     (Sout_Rdata_ram),
        .Sout_DataRdy       (Sout_DataRdy),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [44];

    task automatic check(input string tag, input int idx,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed 0x%0h required 0x%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic void model_preset();
        int pv [11] = '{44, 7, -3, 19, 0, 7, 100, -50, 12, 3, 1};
        for (int e = 0; e < 11; e++)
            for (int b = 0; b < 4; b++)
                ref_mem[4*e+b] = 8'(pv[e] >>> (8*b));
    endfunction

    function automatic void model_sort();
        int v [11];
        int t;
        int p;
        for (int e = 0; e < 11; e++)
            v[e] = int'({ref_mem[4*e+3], ref_mem[4*e+2], ref_mem[4*e+1], ref_mem[4*e]});
        for (int e = 1; e < 11; e++) begin
            t = v[e];
            p = e - 1;
            while (p >= 0 && v[p] > t) begin
                v[p+1] = v[p];
                p--;
            end
            v[p+1] = t;
        end
        for (int e = 0; e < 11; e++)
            for (int b = 0; b < 4; b++)
                ref_mem[4*e+b] = 8'(v[e] >>> (8*b));
    endfunction

    // ---------------- bus helpers ----------------
    task automatic s_read(input int ch, input int addr, input logic [7:0] exp, input string tag);
        S_oe_ram[ch]            = 1'b1;
        S_addr_ram[7*ch +: 7]   = 7'(addr);
        tick();
        check({tag, "_rdy"}, addr, 32'(Sout_DataRdy[ch]), 32'd1);
        check(tag, addr, 32'(Sout_Rdata_ram[8*ch +: 8]), 32'(exp));
        S_oe_ram[ch]            = 1'b0;
        S_addr_ram[7*ch +: 7]   = 7'd0;
    endtask

    task automatic s_write(input int ch, input int addr, input logic [7:0] data, input int size);
        int mask;
        S_we_ram[ch]                = 1'b1;
        S_addr_ram[7*ch +: 7]       = 7'(addr);
        S_Wdata_ram[8*ch +: 8]      = data;
        S_data_ram_size[4*ch +: 4]  = 4'(size);
        tick();
        check("wr_ack", addr, 32'(Sout_DataRdy[ch]), 32'd1);
        S_we_ram[ch]                = 1'b0;
        S_addr_ram[7*ch +: 7]       = 7'd0;
        S_Wdata_ram[8*ch +: 8]      = 8'd0;
        S_data_ram_size[4*ch +: 4]  = 4'd0;
        mask = (1 << size) - 1;
        ref_mem[addr-32] = 8'((int'(ref_mem[addr-32]) & ~mask) | (int'(data) & mask));
    endtask

    task automatic readback_all(input string tag);
        for (int a = 0; a < 44; a++)
            s_read(a % 2, 32 + a, ref_mem[a], tag);
    endtask

    task automatic pulse_start();
        start_port = 1'b1;
        tick();
        start_port = 1'b0;
    endtask

    // Waits for done (bounded), checks it is a single-cycle pulse, then
    // brings the model up to date.
    task automatic wait_done(input string tag);
        int cyc;
        cyc = 1;
        while (!done_port && cyc < 1000) begin
            tick();
            cyc++;
        end
        check({tag, "_done"}, cyc, 32'(done_port), 32'd1);
        tick();
        check({tag, "_done_width"}, cyc, 32'(done_port), 32'd0);
        model_sort();
    endtask

    // Master bus must stay quiet for the whole run.
    always @(negedge clock) begin
        check("mout_ctrl", 0, 32'({Mout_oe_ram, Mout_we_ram}), 32'd0);
        check("mout_bus", 0, 32'(|{Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size}), 32'd0);
    end

    initial begin
        logic [7:0] bvals [4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
        logic [7:0] d;

        reset = 1'b1; start_port = 1'b0;
        S_oe_ram = '0; S_we_ram = '0; S_addr_ram = '0; S_Wdata_ram = '0;
        S_data_ram_size = '0; M_Rdata_ram = 16'hA5A5; M_DataRdy = 2'b11;
        tick(); tick();
        check("rst_done", 0, 32'(done_port), 32'd0);
        check("rst_rdy", 0, 32'(Sout_DataRdy), 32'd0);
        check("rst_rdata", 0, 32'(Sout_Rdata_ram), 32'd0);
        reset = 1'b0;
        model_preset();
        tick();

        // Preset contents visible before any sort.
        s_read(0, 32, 8'h2C, "preset_b32");
        readback_all("preset");

        // Sort the preset.
        pulse_start();
        wait_done("sort_preset");
        s_read(0, 32, 8'hCE, "sorted_b32");
        s_read(1, 35, 8'hFF, "sorted_b35");
        readback_all("sorted_preset");

        // Simultaneous reads on both channels.
        S_oe_ram = 2'b11; S_addr_ram = {7'd33, 7'd32};
        tick();
        check("dual_rdy", 0, 32'(Sout_DataRdy), 32'd3);
        check("dual_data", 0, 32'(Sout_Rdata_ram), 32'({ref_mem[1], ref_mem[0]}));
        S_oe_ram = 2'b00; S_addr_ram = '0;

        // Descending 10..0 written byte-wise, then re-sort.
        for (int e = 0; e < 11; e++)
            for (int b = 0; b < 4; b++)
                s_write(b % 2, 32 + 4*e + b, (b == 0) ? 8'(10 - e) : 8'h00, 8);
        pulse_start();
        wait_done("sort_desc");
        s_read(0, 36, 8'h01, "desc_b36");
        readback_all("sorted_desc");

        // Masked write.
        s_write(0, 36, 8'hF9, 8);
        s_write(1, 36, 8'hAB, 4);
        s_read(0, 36, 8'hFB, "masked_b36");

        // Both channels write the same byte: channel 1 wins.
        S_we_ram = 2'b11; S_addr_ram = {7'd40, 7'd40};
        S_Wdata_ram = 16'h2211; S_data_ram_size = 8'h88;
        tick();
        check("coll_ack", 0, 32'(Sout_DataRdy), 32'd3);
        S_we_ram = 2'b00; S_addr_ram = '0; S_Wdata_ram = '0; S_data_ram_size = '0;
        ref_mem[8] = 8'h22;
        s_read(1, 40, 8'h22, "coll_b40");

        // oe and we together act as a plain read.
        S_oe_ram[0] = 1'b1; S_we_ram[0] = 1'b1; S_addr_ram[6:0] = 7'd41;
        S_Wdata_ram[7:0] = 8'h55; S_data_ram_size[3:0] = 4'd8;
        tick();
        check("oewe_rdy", 41, 32'(Sout_DataRdy[0]), 32'd1);
        check("oewe_data", 41, 32'(Sout_Rdata_ram[7:0]), 32'(ref_mem[9]));
        S_oe_ram = '0; S_we_ram = '0; S_addr_ram = '0; S_Wdata_ram = '0; S_data_ram_size = '0;
        s_read(0, 41, ref_mem[9], "oewe_after");

        // Out-of-range read on channel 1.
        S_oe_ram[1] = 1'b1; S_addr_ram[13:7] = 7'd10;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("oor_rdy", k, 32'(Sout_DataRdy[1]), 32'd0);
            check("oor_data", k, 32'(Sout_Rdata_ram[15:8]), 32'd0);
        end
        S_oe_ram = '0; S_addr_ram = '0;

        // Requests while busy are held off; a second start is ignored.
        pulse_start();
        S_oe_ram[0] = 1'b1; S_addr_ram[6:0] = 7'd32;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("busy_rdy", k, 32'(Sout_DataRdy[0]), 32'd0);
        end
        S_oe_ram = '0; S_addr_ram = '0;
        start_port = 1'b1; tick(); start_port = 1'b0;
        wait_done("sort_busy");
        readback_all("sorted_busy");

        // Randomized contents: random, boundary bytes, small duplicates.
        for (int it = 0; it < 5; it++) begin
            for (int a = 0; a < 44; a++) begin
                if (it == 3)
                    s_write(a % 2, 32 + a, bvals[$urandom_range(0, 3)], 8);
                else if (it == 4)
                    s_write(a % 2, 32 + a, (a % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'h00, 8);
                else begin
                    d = 8'($urandom);
                    s_write($urandom_range(0, 1), 32 + a, d, $urandom_range(1, 8));
                end
            end
            pulse_start();
            wait_done("sort_rand");
            readback_all("sorted_rand");
        end

        // Reset in the middle of a sort.
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            check("abort_no_done", k, 32'(done_port), 32'd0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_done_low", 0, 32'(done_port), 32'd0);
        tick();
        check("abort_done_low", 1, 32'(done_port), 32'd0);
        model_preset();
        s_read(0, 32, 8'h2C, "abort_b32");
        readback_all("abort_preset");
        pulse_start();
        wait_done("sort_after_abort");
        readback_all("sorted_after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quicksort_main.md
Name: quicksort_main

Overview:
- HLS-style top that sorts a fixed 11-element array of signed 32-bit integers (44 bytes) in place, ascending.
- The array lives in internal RAM, preloaded with constant contents.
- Start/done handshake.
- A dual-channel, byte-wide slave bus lets a testbench or SoC read back or overwrite the array.
- The master bus is present for interface compatibility but is never driven active.

Parameters:
- MEM_var_28860_28869, 32: byte base address of the array in the 7-bit address space (array occupies base..base+43).
- MEM_var_29126_28866, 32: byte base address of the result view. It aliases the same storage and must equal MEM_var_28860_28869.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- start_port, in, 1: one-cycle start pulse.
- S_oe_ram, in, 2: per-channel slave read enable.
- S_we_ram, in, 2: per-channel slave write enable.
- S_addr_ram, in, 14: channel c byte address at bits [7c+6:7c].
- S_Wdata_ram, in, 16: channel c write byte at bits [8c+7:8c].
- S_data_ram_size, in, 8: channel c access size in bits at [4c+3:4c]; valid 1..8.
- M_Rdata_ram, in, 16: master read data; ignored.
- M_DataRdy, in, 2: master ready; ignored.
- done_port, out, 1: one-cycle completion pulse.
- Sout_Rdata_ram, out, 16: slave read data per channel.
- Sout_DataRdy, out, 2: slave ready per channel.
- Mout_oe_ram, out, 2: master read enable; constant 0.
- Mout_we_ram, out, 2: master write enable; constant 0.
- Mout_addr_ram, out, 14: master address; constant 0.
- Mout_Wdata_ram, out, 16: master write data; constant 0.
- Mout_data_ram_size, out, 8: master access size; constant 0.

Behaviour:
- Storage: 44-byte RAM, element i at bytes base+4i..base+4i+3, little-endian.
- Preset contents, elements 0..10: 44, 7, -3, 19, 0, 7, 100, -50, 12, 3, 1.
- Reset: RAM reloads the preset; FSM goes to IDLE; done_port=0; Sout_Rdata_ram=0; Sout_DataRdy=0.
- All Mout_* outputs are constant 0 at all times. No combinational path exists from any S_* input to any Mout_* output, which avoids loops when looped back externally.
- FSM states:
  - IDLE: on start_port=1, push range (0,10) on a stack and go to POP.
  - POP: if the stack is empty, go to DONE. Otherwise pop (lo,hi); if lo>=hi, stay in POP; else go to PART.
  - PART: Lomuto partition, pivot = a[hi], signed compare (a[j] < pivot moves left). One element compare/swap step per cycle or two.
  - PART end: push (lo,p-1) and (p+1,hi).
  - DONE: assert done_port for exactly 1 cycle, then return to IDLE.
- Stack depth is 11 entries; it never overflows for N=11.
- Total latency from start_port to done_port is at most 1000 cycles for any data.
- start_port is ignored while busy.
- Issuing start again while IDLE re-sorts the current RAM contents; the preset is not reloaded, only reset reloads it.
- Reset mid-sort aborts, reloads the preset, and returns to IDLE with no done pulse.
- Slave bus, per channel c, independent:
  - A request hits when S_addr_ram[c] lies in [base, base+44).
  - Read hit: Sout_Rdata_ram byte = RAM byte, registered; Sout_DataRdy[c]=1 exactly one cycle after the request cycle.
  - Write hit: at the request clock edge, bits selected by mask = (1<<size)-1 are replaced; unmasked bits are kept. Sout_DataRdy[c]=1 on the following cycle.
  - Miss or no request: Sout_Rdata_ram byte = 0 and Sout_DataRdy[c] = 0.
  - oe and we both high on the same channel is illegal; treat it as a read, with no write.
  - Both channels writing the same byte in the same cycle: channel 1 wins.
  - Slave requests while the FSM is not IDLE are not acknowledged (DataRdy stays 0) until IDLE; the requester holds the request.

Test Plan:
- Reset, then pulse start_port for 1 cycle -> done_port pulses once within 1000 cycles. Slave reads of bytes 32..75 then give -50, -3, 0, 1, 3, 7, 7, 12, 19, 44, 100 (e.g. byte 32 = 0xCE, byte 35 = 0xFF).
- After sort, slave-write bytes 32..75 with 11 descending values 10..0 (size=8), then start -> readback 0..10 ascending; each write acked with DataRdy one cycle later.
- Masked write: size=4, data 0xAB to byte 36 holding 0xF9 -> reads 0xFB.
- Out-of-range access at address 10 on channel 1 with oe=1 -> Sout_DataRdy[1]=0 and Sout_Rdata_ram[15:8]=0, indefinitely. Over the whole simulation, Mout_oe/we remain 0.
- Reset asserted 20 cycles after start -> no done pulse; RAM reads back the preset (byte 32 = 0x2C); a new start completes normally.
- Simultaneous reads on both channels (bytes 32 and 33) -> both DataRdy bits high together one cycle later with the correct bytes.
